apb_timeout_guard: RTL and testbench
====================================

APB_TIMEOUT_GUARD -- requirements
Module: apb_timeout_guard

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 24, APB address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, APB data width.
REQ-003 SHALL have parameter TIMEOUT, default 255, max cycles in ACCESS before abort (range 1..65535).
REQ-004 SHALL have parameter ERR_DATA, default 32'hDEADBEEF, read data returned on abort.
REQ-005 SHALL have one clock and an asynchronous, active-high reset, as follows.
REQ-006 clk  in  1  sole clock; all state on rising edge.
REQ-007 rst  in  1  asynchronous active-high reset.
REQ-008 up_psel, up_penable, up_pwrite  in  1 each  request from management bridge; psel/penable may rise together.
REQ-009 up_paddr  in  ADDR_WIDTH;  up_pwdata  in  DATA_WIDTH;  up_pstrb  in  DATA_WIDTH/8  upstream request fields.
REQ-010 up_pready  out  1;  up_prdata  out  DATA_WIDTH;  up_pslverr  out  1  upstream completion.
REQ-011 dn_psel, dn_penable, dn_pwrite  out  1 each;  dn_paddr  out  ADDR_WIDTH;  dn_pwdata  out  DATA_WIDTH;  dn_pstrb  out  DATA_WIDTH/8  downstream APB request to fabric.
REQ-012 dn_pready  in  1;  dn_prdata  in  DATA_WIDTH;  dn_pslverr  in  1  downstream completion.
REQ-013 timeout_pulse  out  1;  timeout_count  out  16;  timeout_addr  out  ADDR_WIDTH  abort status.

Function
REQ-014 FSM states SHALL be IDLE, SETUP, ACCESS, RESP; all outputs registered.
REQ-015 IDLE: on up_psel=1 SHALL latch paddr/pwrite/pwdata/pstrb and go SETUP; up_penable level ignored for acceptance.
REQ-016 SETUP (1 cycle): dn_psel=1, dn_penable=0, latched fields on dn_*; next state ACCESS.
REQ-017 ACCESS: dn_psel=1, dn_penable=1, fields held stable; 16-bit wait counter cleared on entry, +1 per ACCESS cycle.
REQ-018 ACCESS with dn_pready=1: SHALL capture dn_prdata, dn_pslverr; go RESP; dn_psel/dn_penable low next cycle.
REQ-019 ACCESS, dn_pready=0, counter==TIMEOUT-1: SHALL abort -> RESP with prdata=ERR_DATA, pslverr=1, dn_psel/dn_penable low next cycle.
REQ-020 Same cycle dn_pready=1 and abort condition: dn_pready SHALL win, no abort recorded.
REQ-021 RESP (exactly 1 cycle): up_pready=1 with captured up_prdata/up_pslverr; up_pready=0 in every other state; next state IDLE.
REQ-022 up_psel still high during RESP SHALL NOT start a new transaction; acceptance only from IDLE.
REQ-023 up_prdata SHALL be 0 outside RESP; on write completion up_prdata = dn_prdata as sampled.
REQ-024 Latency: up_psel seen at cycle 0 -> dn_psel cycle 1, dn_penable cycle 2; dn_pready at cycle k -> up_pready cycle k+1.
REQ-025 Abort: timeout_pulse=1 for the RESP cycle only; timeout_addr = aborted address; timeout_count +1, saturating at 16'hFFFF.
REQ-026 up_psel deasserting mid-transaction SHALL NOT cancel the downstream access.

Reset
REQ-027 rst=1 SHALL immediately force IDLE, all dn_*/up_* outputs 0, timeout_pulse 0, timeout_count 0, timeout_addr 0, wait counter 0.
REQ-028 rst mid-ACCESS SHALL drop dn_psel/dn_penable asynchronously with no up_pready issued; first request after release is accepted normally.

Verification
REQ-029 Read 0x000010, completer pready 3 cycles after dn_penable, prdata 0x12345678 -> up_pready 1 cycle, up_prdata 0x12345678, pslverr 0, timeout_count 0.
REQ-030 Write 0x000004 data 0xCAFEF00D strb 4'hF, zero-wait completer -> dn_pwdata 0xCAFEF00D stable SETUP..ACCESS, up_pready at cycle 3.
REQ-031 Read 0x00ABCD, completer never ready, TIMEOUT=255 -> up_pready after 255 ACCESS cycles, prdata 0xDEADBEEF, pslverr 1, timeout_pulse 1, timeout_addr 0x00ABCD, timeout_count 1.
REQ-032 dn_pready on ACCESS cycle 255 exactly -> normal completion, pslverr from completer, timeout_count unchanged.
REQ-033 up_psel held high through RESP, dropped next cycle -> exactly one downstream transaction.
REQ-034 rst pulse during ACCESS -> dn_psel 0 same cycle, no up_pready; subsequent read completes normally.

Source files
------------

// File: rtl/apb_timeout_guard.sv
// rtl/apb_timeout_guard.sv - APB bridge that forwards one access and aborts it after a wait budget

module apb_timeout_guard #(
   parameter int                    ADDR_WIDTH = 24,
   parameter int                    DATA_WIDTH = 32,
   parameter int                    TIMEOUT    = 255,
   parameter logic [DATA_WIDTH-1:0] ERR_DATA   = DATA_WIDTH'(32'hDEADBEEF)
) (
   input  logic                      clk,
   input  logic                      rst,

   // upstream request from the management bridge
   input  logic                      up_psel,
   input  logic                      up_penable,
   input  logic                      up_pwrite,
   input  logic [ADDR_WIDTH-1:0]     up_paddr,
   input  logic [DATA_WIDTH-1:0]     up_pwdata,
   input  logic [DATA_WIDTH/8-1:0]   up_pstrb,
   output logic                      up_pready,
   output logic [DATA_WIDTH-1:0]     up_prdata,
   output logic                      up_pslverr,

   // downstream APB towards the fabric
   output logic                      dn_psel,
   output logic                      dn_penable,
   output logic                      dn_pwrite,
   output logic [ADDR_WIDTH-1:0]     dn_paddr,
   output logic [DATA_WIDTH-1:0]     dn_pwdata,
   output logic [DATA_WIDTH/8-1:0]   dn_pstrb,
   input  logic                      dn_pready,
   input  logic [DATA_WIDTH-1:0]     dn_prdata,
   input  logic                      dn_pslverr,

   // abort status
   output logic                      timeout_pulse,
   output logic [15:0]               timeout_count,
   output logic [ADDR_WIDTH-1:0]     timeout_addr
);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SETUP  = 2'd1,
      ST_ACCESS = 2'd2,
      ST_RESP   = 2'd3
   } state_t;

   // last ACCESS cycle index that may still complete before the abort fires
   localparam logic [15:0] ABORT_AT = 16'(TIMEOUT - 1);

   state_t                    state_q;
   logic [15:0]               wait_cnt_q;
   logic [15:0]               wait_cnt_d;
   logic [15:0]               timeout_count_q;
   logic [15:0]               timeout_count_d;
   logic                      abort_hit;

   logic                      up_pready_q;
   logic [DATA_WIDTH-1:0]     up_prdata_q;
   logic                      up_pslverr_q;
   logic                      dn_psel_q;
   logic                      dn_penable_q;
   logic                      dn_pwrite_q;
   logic [ADDR_WIDTH-1:0]     dn_paddr_q;
   logic [DATA_WIDTH-1:0]     dn_pwdata_q;
   logic [DATA_WIDTH/8-1:0]   dn_pstrb_q;
   logic                      timeout_pulse_q;
   logic [ADDR_WIDTH-1:0]     timeout_addr_q;

   // acceptance only looks at psel, so penable has no role in this bridge
   logic                      unused_penable;
   assign unused_penable = up_penable;

   // next values for the wait counter, the saturating abort counter and the abort condition;
   // a ready completer in the same cycle always takes priority over the abort
   always_comb begin
      wait_cnt_d      = wait_cnt_q + 16'd1;
      timeout_count_d = (timeout_count_q == 16'hFFFF) ? timeout_count_q
                                                      : timeout_count_q + 16'd1;
      abort_hit       = (state_q == ST_ACCESS) && !dn_pready && (wait_cnt_q == ABORT_AT);
   end

   // transaction FSM; every output is a register updated alongside the state
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q         <= ST_IDLE;
         wait_cnt_q      <= '0;
         timeout_count_q <= '0;
         up_pready_q     <= 1'b0;
         up_prdata_q     <= '0;
         up_pslverr_q    <= 1'b0;
         dn_psel_q       <= 1'b0;
         dn_penable_q    <= 1'b0;
         dn_pwrite_q     <= 1'b0;
         dn_paddr_q      <= '0;
         dn_pwdata_q     <= '0;
         dn_pstrb_q      <= '0;
         timeout_pulse_q <= 1'b0;
         timeout_addr_q  <= '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (up_psel) begin
                  dn_psel_q   <= 1'b1;
                  dn_penable_q <= 1'b0;
                  dn_pwrite_q <= up_pwrite;
                  dn_paddr_q  <= up_paddr;
                  dn_pwdata_q <= up_pwdata;
                  dn_pstrb_q  <= up_pstrb;
                  state_q     <= ST_SETUP;
               end
            end

            ST_SETUP: begin
               dn_penable_q <= 1'b1;
               wait_cnt_q   <= '0;
               state_q      <= ST_ACCESS;
            end

            ST_ACCESS: begin
               if (dn_pready) begin
                  up_pready_q  <= 1'b1;
                  up_prdata_q  <= dn_prdata;
                  up_pslverr_q <= dn_pslverr;
                  dn_psel_q    <= 1'b0;
                  dn_penable_q <= 1'b0;
                  state_q      <= ST_RESP;
               end else if (abort_hit) begin
                  up_pready_q     <= 1'b1;
                  up_prdata_q     <= ERR_DATA;
                  up_pslverr_q    <= 1'b1;
                  dn_psel_q       <= 1'b0;
                  dn_penable_q    <= 1'b0;
                  timeout_pulse_q <= 1'b1;
                  timeout_addr_q  <= dn_paddr_q;
                  timeout_count_q <= timeout_count_d;
                  state_q         <= ST_RESP;
               end else begin
                  wait_cnt_q <= wait_cnt_d;
               end
            end

            ST_RESP: begin
               // completion is shown for exactly this one cycle, then everything returns to idle
               up_pready_q     <= 1'b0;
               up_prdata_q     <= '0;
               up_pslverr_q    <= 1'b0;
               timeout_pulse_q <= 1'b0;
               wait_cnt_q      <= '0;
               state_q         <= ST_IDLE;
            end

            default: begin
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   assign up_pready     = up_pready_q;
   assign up_prdata     = up_prdata_q;
   assign up_pslverr    = up_pslverr_q;
   assign dn_psel       = dn_psel_q;
   assign dn_penable    = dn_penable_q;
   assign dn_pwrite     = dn_pwrite_q;
   assign dn_paddr      = dn_paddr_q;
   assign dn_pwdata     = dn_pwdata_q;
   assign dn_pstrb      = dn_pstrb_q;
   assign timeout_pulse = timeout_pulse_q;
   assign timeout_count = timeout_count_q;
   assign timeout_addr  = timeout_addr_q;

endmodule

// File: tb/tb_apb_timeout_guard.sv
// tb/tb_apb_timeout_guard.sv - directed self-checking bench for apb_timeout_guard

module tb_apb_timeout_guard;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        up_psel = 0, up_penable = 0, up_pwrite = 0;
   logic [23:0] up_paddr = '0;
   logic [31:0] up_pwdata = '0;
   logic [3:0]  up_pstrb = '0;
   logic        up_pready;
   logic [31:0] up_prdata;
   logic        up_pslverr;
   logic        dn_psel, dn_penable, dn_pwrite;
   logic [23:0] dn_paddr;
   logic [31:0] dn_pwdata;
   logic [3:0]  dn_pstrb;
   logic        dn_pready = 0;
   logic [31:0] dn_prdata = '0;
   logic        dn_pslverr = 0;
   logic        timeout_pulse;
   logic [15:0] timeout_count;
   logic [23:0] timeout_addr;

   int checks = 0;
   int errors = 0;
   int dn_txn = 0;
   int up_resp = 0;
   logic dn_psel_prev = 1'b0;

   apb_timeout_guard dut (
      .clk(clk), .rst(rst),
      .up_psel(up_psel), .up_penable(up_penable), .up_pwrite(up_pwrite),
      .up_paddr(up_paddr), .up_pwdata(up_pwdata), .up_pstrb(up_pstrb),
      .up_pready(up_pready), .up_prdata(up_prdata), .up_pslverr(up_pslverr),
      .dn_psel(dn_psel), .dn_penable(dn_penable), .dn_pwrite(dn_pwrite),
      .dn_paddr(dn_paddr), .dn_pwdata(dn_pwdata), .dn_pstrb(dn_pstrb),
      .dn_pready(dn_pready), .dn_prdata(dn_prdata), .dn_pslverr(dn_pslverr),
      .timeout_pulse(timeout_pulse), .timeout_count(timeout_count), .timeout_addr(timeout_addr)
   );

   always #5 clk = ~clk;

   // count downstream transactions (dn_psel rising) and upstream completions
   always @(negedge clk) begin
      if (dn_psel && !dn_psel_prev) dn_txn++;
      if (up_pready) up_resp++;
      dn_psel_prev = dn_psel;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      #1;
      checks++; if (dn_psel !== 1'b0) begin errors++; $display("FAIL reset_dn_psel got %b exp 0", dn_psel); end
      checks++; if (up_pready !== 1'b0) begin errors++; $display("FAIL reset_up_pready got %b exp 0", up_pready); end
      checks++; if (up_prdata !== 32'h0) begin errors++; $display("FAIL reset_up_prdata got %h exp 0", up_prdata); end
      checks++; if ({timeout_pulse, timeout_count, timeout_addr} !== 41'h0) begin errors++; $display("FAIL reset_status got %b %h %h exp 0", timeout_pulse, timeout_count, timeout_addr); end
      tick();
      tick();
      rst = 1'b0;
      tick();
   endtask

   task automatic test_read();
      int bad = 0;
      up_psel = 1; up_pwrite = 0; up_paddr = 24'h000010;          // cycle 0
      tick();                                                       // cycle 1: SETUP
      checks++; if ({dn_psel, dn_penable, dn_pwrite} !== 3'b100) begin errors++; $display("FAIL read_setup got %b exp 100", {dn_psel, dn_penable, dn_pwrite}); end
      checks++; if (dn_paddr !== 24'h000010) begin errors++; $display("FAIL read_addr got %h exp 000010", dn_paddr); end
      up_psel = 0;
      tick();                                                       // cycle 2: ACCESS
      checks++; if ({dn_psel, dn_penable} !== 2'b11) begin errors++; $display("FAIL read_access got %b exp 11", {dn_psel, dn_penable}); end
      for (int c = 2; c <= 4; c++) begin
         if (up_pready !== 1'b0 || dn_penable !== 1'b1) bad++;
         tick();
      end
      checks++; if (bad != 0) begin errors++; $display("FAIL read_wait got %0d bad cycles exp 0", bad); end
      dn_pready = 1; dn_prdata = 32'h12345678;                     // cycle 5
      tick();                                                       // cycle 6: RESP
      dn_pready = 0; dn_prdata = 32'h0;
      checks++; if ({up_pready, up_pslverr} !== 2'b10) begin errors++; $display("FAIL read_resp got %b exp 10", {up_pready, up_pslverr}); end
      checks++; if (up_prdata !== 32'h12345678) begin errors++; $display("FAIL read_prdata got %h exp 12345678", up_prdata); end
      checks++; if ({dn_psel, dn_penable} !== 2'b00) begin errors++; $display("FAIL read_dn_drop got %b exp 00", {dn_psel, dn_penable}); end
      checks++; if (timeout_count !== 16'd0) begin errors++; $display("FAIL read_tcount got %0d exp 0", timeout_count); end
      tick();                                                       // cycle 7: IDLE
      checks++; if ({up_pready, up_prdata} !== 33'h0) begin errors++; $display("FAIL read_after got %b %h exp 0 0", up_pready, up_prdata); end
   endtask

   task automatic test_write();
      up_psel = 1; up_pwrite = 1; up_paddr = 24'h000004; up_pwdata = 32'hCAFEF00D; up_pstrb = 4'hF;
      tick();                                                       // cycle 1: SETUP
      checks++; if ({dn_psel, dn_penable, dn_pwrite} !== 3'b101) begin errors++; $display("FAIL write_setup got %b exp 101", {dn_psel, dn_penable, dn_pwrite}); end
      checks++; if ({dn_pwdata, dn_pstrb} !== {32'hCAFEF00D, 4'hF}) begin errors++; $display("FAIL write_setup_data got %h %h exp cafef00d f", dn_pwdata, dn_pstrb); end
      up_penable = 1; up_pwdata = 32'h0; up_pstrb = 4'h0;
      tick();                                                       // cycle 2: ACCESS
      checks++; if ({dn_penable, dn_pwdata, dn_pstrb} !== {1'b1, 32'hCAFEF00D, 4'hF}) begin errors++; $display("FAIL write_access_data got %b %h %h exp 1 cafef00d f", dn_penable, dn_pwdata, dn_pstrb); end
      dn_pready = 1; dn_prdata = 32'h0BADF00D;
      tick();                                                       // cycle 3: RESP
      dn_pready = 0; dn_prdata = 32'h0; up_psel = 0; up_penable = 0; up_pwrite = 0;
      checks++; if ({up_pready, up_pslverr} !== 2'b10) begin errors++; $display("FAIL write_resp got %b exp 10", {up_pready, up_pslverr}); end
      checks++; if (up_prdata !== 32'h0BADF00D) begin errors++; $display("FAIL write_prdata got %h exp 0badf00d", up_prdata); end
      tick();
   endtask

   // drives a read that stalls; the completer answers on ACCESS cycle rdy_at (0 = never)
   task automatic run_stall(input logic [23:0] addr, input int rdy_at, output int bad);
      bad = 0;
      up_psel = 1; up_pwrite = 0; up_paddr = addr;
      tick();
      up_psel = 0;
      tick();                                                       // ACCESS cycle 1
      for (int n = 1; n <= 255; n++) begin
         if (up_pready !== 1'b0 || dn_penable !== 1'b1) bad++;
         if (n == rdy_at) begin dn_pready = 1; dn_prdata = 32'h000055AA; dn_pslverr = 1; end
         tick();
      end
      dn_pready = 0; dn_prdata = 32'h0; dn_pslverr = 0;
   endtask

   task automatic test_timeout();
      int bad;
      run_stall(24'h00ABCD, 0, bad);
      checks++; if (bad != 0) begin errors++; $display("FAIL timeout_wait got %0d bad cycles exp 0", bad); end
      checks++; if ({up_pready, up_pslverr, timeout_pulse} !== 3'b111) begin errors++; $display("FAIL timeout_resp got %b exp 111", {up_pready, up_pslverr, timeout_pulse}); end
      checks++; if (up_prdata !== 32'hDEADBEEF) begin errors++; $display("FAIL timeout_prdata got %h exp deadbeef", up_prdata); end
      checks++; if (timeout_addr !== 24'h00ABCD) begin errors++; $display("FAIL timeout_addr got %h exp 00abcd", timeout_addr); end
      checks++; if (timeout_count !== 16'd1) begin errors++; $display("FAIL timeout_count got %0d exp 1", timeout_count); end
      checks++; if (dn_psel !== 1'b0) begin errors++; $display("FAIL timeout_dn_drop got %b exp 0", dn_psel); end
      tick();
      checks++; if ({timeout_pulse, up_pready} !== 2'b00) begin errors++; $display("FAIL timeout_pulse_len got %b exp 00", {timeout_pulse, up_pready}); end
   endtask

   task automatic test_ready_at_limit();
      int bad;
      run_stall(24'h000020, 255, bad);
      checks++; if (bad != 0) begin errors++; $display("FAIL limit_wait got %0d bad cycles exp 0", bad); end
      checks++; if ({up_pready, up_pslverr, timeout_pulse} !== 3'b110) begin errors++; $display("FAIL limit_resp got %b exp 110", {up_pready, up_pslverr, timeout_pulse}); end
      checks++; if (up_prdata !== 32'h000055AA) begin errors++; $display("FAIL limit_prdata got %h exp 000055aa", up_prdata); end
      checks++; if ({timeout_count, timeout_addr} !== {16'd1, 24'h00ABCD}) begin errors++; $display("FAIL limit_status got %0d %h exp 1 00abcd", timeout_count, timeout_addr); end
      tick();
   endtask

   task automatic test_back_to_back();
      int txn0 = dn_txn;
      up_psel = 1; up_pwrite = 0; up_paddr = 24'h000030;
      tick(); tick();                                               // cycle 2: ACCESS
      dn_pready = 1;
      tick();                                                       // cycle 3: RESP, psel still high
      dn_pready = 0;
      checks++; if (up_pready !== 1'b1) begin errors++; $display("FAIL b2b_resp got %b exp 1", up_pready); end
      tick();                                                       // cycle 4: IDLE
      up_psel = 0;
      checks++; if (dn_psel !== 1'b0) begin errors++; $display("FAIL b2b_no_restart got %b exp 0", dn_psel); end
      tick(); tick(); tick();
      checks++; if (dn_txn - txn0 != 1) begin errors++; $display("FAIL b2b_txn_count got %0d exp 1", dn_txn - txn0); end
   endtask

   task automatic test_reset_mid();
      int resp0 = up_resp;
      up_psel = 1; up_pwrite = 0; up_paddr = 24'h000040;
      tick();
      up_psel = 0;
      tick(); tick();                                               // second ACCESS cycle
      rst = 1;
      #1;
      checks++; if ({dn_psel, dn_penable} !== 2'b00) begin errors++; $display("FAIL rstmid_dn got %b exp 00", {dn_psel, dn_penable}); end
      checks++; if (timeout_count !== 16'd0) begin errors++; $display("FAIL rstmid_tcount got %0d exp 0", timeout_count); end
      tick();
      rst = 0;
      tick(); tick();
      checks++; if (up_resp != resp0) begin errors++; $display("FAIL rstmid_no_pready got %0d exp 0", up_resp - resp0); end
      up_psel = 1; up_paddr = 24'h000044;
      tick();
      up_psel = 0;
      checks++; if ({dn_psel, dn_paddr} !== {1'b1, 24'h000044}) begin errors++; $display("FAIL rstmid_restart got %b %h exp 1 000044", dn_psel, dn_paddr); end
      tick();
      dn_pready = 1; dn_prdata = 32'hA5A5_0001;
      tick();
      dn_pready = 0; dn_prdata = 32'h0;
      checks++; if ({up_pready, up_pslverr, up_prdata} !== {2'b10, 32'hA5A5_0001}) begin errors++; $display("FAIL rstmid_read got %b %b %h exp 1 0 a5a50001", up_pready, up_pslverr, up_prdata); end
      tick();
   endtask

   initial begin
      test_reset();
      test_read();
      test_write();
      test_timeout();
      test_ready_at_limit();
      test_back_to_back();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
